j_pixel_scan_ctrl: RTL and testbench
====================================

Name: j_pixel_scan_ctrl

Overview:
- Raster-scan controller for image indexing.
- On `start`, walks every pixel of a W x H frame in row-major order and issues one byte address per pixel to the downstream pixel fetch over a valid/ready handshake.
- Emits a one-cycle `row_advance` strobe on the last column of each row. That strobe drives `count_enable` of `j_row_counter`, so the row counter stays in lockstep with the scan.
- Sits between the top-level control FSM and the SRAM read interface / row counter.

Parameters:
- DIM_W, 13, width of image dimension inputs and column/row indices.
- ADDR_W, 32, width of byte addresses.
- BPP, 3, bytes per pixel (address increment per column).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clear  in  1  synchronous active-high reset.
- start  in  1  begin a frame scan; honoured only in IDLE.
- abort  in  1  abandon the current frame and return to IDLE.
- img_width  in  DIM_W  pixels per row; sampled on accepted start.
- img_height  in  DIM_W  rows per frame; sampled on accepted start.
- base_addr  in  ADDR_W  byte address of pixel (0,0); sampled on accepted start.
- line_stride  in  ADDR_W  byte distance between row starts; sampled on accepted start.
- ready  in  1  downstream accepts the current address.
- valid  out  1  `pixel_addr`/`col`/`row` are valid.
- pixel_addr  out  ADDR_W  byte address of the current pixel.
- col  out  DIM_W  current column index.
- row  out  DIM_W  current row index.
- row_advance  out  1  one-cycle strobe: last pixel of a row transferred.
- frame_done  out  1  one-cycle strobe: frame finished.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- `clear` (sync, highest priority):
  - state=IDLE; col=row=0; pixel_addr=0; row_base=0.
  - valid=row_advance=frame_done=busy=0.
  - Latched dimensions are zeroed.
  - Takes effect on the next posedge even mid-frame; no strobe is emitted.
- States: IDLE, SCAN, DONE.
- IDLE:
  - valid=0.
  - On start=1: latch width, height, base, stride; set col=row=0, pixel_addr=base, row_base=base.
  - If width==0 or height==0, go to DONE; otherwise go to SCAN.
- SCAN:
  - valid=1. A transfer occurs when valid&&ready.
  - pixel_addr, col and row are held stable while valid&&!ready (no change without a transfer).
  - Transfer with col<W-1: col+=1; pixel_addr+=BPP.
  - Transfer with col==W-1 and row<H-1: col=0; row+=1; row_base+=stride; pixel_addr=row_base+stride. row_advance=1 in that same cycle.
  - Transfer with col==W-1 and row==H-1: row_advance=1; go to DONE.
  - First valid appears the cycle after start is accepted (1-cycle latency).
  - Throughput is 1 address per cycle with ready tied high.
- `row_advance`:
  - Combinational: valid&&ready&&(col==W-1).
  - Exactly H pulses per frame.
  - The row counter sees its final pulse as its rollover.
- DONE: frame_done=1 for exactly one cycle; valid=0; next state IDLE.
- `abort` (sync, below clear): from SCAN or DONE, go to IDLE next cycle.
  - col, row and pixel_addr reset to 0.
  - No frame_done; row_advance is suppressed in the abort cycle.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: abort wins (stay IDLE).
- Arithmetic:
  - Address adds are modulo 2^ADDR_W; wrap is silent.
  - Indices never exceed W-1/H-1.
  - W=H=8191 is legal.
- `busy` = (state != IDLE).

Decomposition:
- Shared package `j_img_pkg`:
  - DIM_W and ADDR_W constants.
  - scan_state_t enum {IDLE, SCAN, DONE}.
- One natural sub-module: `j_scan_addr_unit`.
  - Holds the row_base/pixel_addr registers and the add logic.
  - Controls: load, col_step, row_step.
- FSM and index counters stay in the top.

Test Plan:
- W=3,H=2,base=0x100,stride=16,BPP=3, ready=1 -> addresses 0x100,0x103,0x106,0x110,0x113,0x116 on consecutive cycles.
  - row_advance pulses on the 3rd and 6th transfers.
  - frame_done fires one cycle after the 6th transfer; busy is low the cycle after that.
- Same frame with ready toggling 1,0,0,1,... -> address/col/row hold stable through the ready=0 cycles; the same 6-address sequence results with no duplicates or skips.
- W=0,H=5, start -> valid never asserted; frame_done=1 one cycle after start; returns to IDLE.
- W=10,H=10; clear asserted after the 37th transfer -> next cycle all outputs 0 and state IDLE. A new start then scans from (0,0) at the new base.
- Mid-scan pulse of start -> ignored, frame completes normally. abort at (2,1) -> IDLE next cycle, no frame_done, no row_advance.
- W=1,H=4, ready=1 -> row_advance high on every transfer (4 pulses).
  - Addresses are base, base+stride, base+2*stride, base+3*stride.
  - A `j_row_counter` driven by row_advance with rollover_val=4 ends at value 0 with rollover_flag=1.

Source files
------------

// File: rtl/j_img_pkg.sv
`default_nettype none
// ============================================================================
// Module   : j_img_pkg
// Purpose  : Shared image-indexing constants and scan state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package j_img_pkg;

    localparam int c_DIM_W  = 13;
    localparam int c_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/j_scan_addr_unit.sv
`default_nettype none
// ============================================================================
// Module   : j_scan_addr_unit
// Purpose  : Row-base and pixel byte-address registers for the raster scan.
// Revision : 1.0 - initial release
// ============================================================================
module j_scan_addr_unit
    import j_img_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int BPP    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_zero,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_line_stride,
    input  logic              i_col_step,
    input  logic              i_row_step,
    output logic [ADDR_W-1:0] o_pixel_addr
);

    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] r_pixel_addr;
    logic [ADDR_W-1:0] w_next_row_base;

    // All adds wrap modulo 2^ADDR_W.
    assign w_next_row_base = r_row_base + r_stride;

    always_ff @(posedge clk) begin
        if (rst || i_zero) begin
            r_row_base   <= '0;
            r_stride     <= '0;
            r_pixel_addr <= '0;
        end else if (i_load) begin
            r_row_base   <= i_base_addr;
            r_stride     <= i_line_stride;
            r_pixel_addr <= i_base_addr;
        end else if (i_row_step) begin
            r_row_base   <= w_next_row_base;
            r_pixel_addr <= w_next_row_base;
        end else if (i_col_step) begin
            r_pixel_addr <= r_pixel_addr + ADDR_W'(BPP);
        end
    end

    assign o_pixel_addr = r_pixel_addr;

endmodule
`default_nettype wire

// File: rtl/j_pixel_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : j_pixel_scan_ctrl
// Purpose  : Row-major raster-scan controller issuing one byte address per pixel.
// Revision : 1.0 - initial release
// ============================================================================
module j_pixel_scan_ctrl
    import j_img_pkg::*;
#(
    parameter int DIM_W  = c_DIM_W,
    parameter int ADDR_W = c_ADDR_W,
    parameter int BPP    = 3
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] line_stride,
    input  logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [DIM_W-1:0]  col,
    output logic [DIM_W-1:0]  row,
    output logic              row_advance,
    output logic              frame_done,
    output logic              busy
);

    scan_state_t      r_state;
    logic             r_valid;
    logic             r_frame_done;
    logic             r_busy;
    logic [DIM_W-1:0] r_col;
    logic [DIM_W-1:0] r_row;
    logic [DIM_W-1:0] r_width;
    logic [DIM_W-1:0] r_height;

    logic w_xfer;
    logic w_last_col;
    logic w_last_row;
    logic w_start_ok;
    logic w_abort;
    logic w_col_step;
    logic w_row_step;

    assign w_xfer     = r_valid & ready;
    assign w_last_col = (r_col == r_width  - DIM_W'(1));
    assign w_last_row = (r_row == r_height - DIM_W'(1));
    assign w_start_ok = (r_state == IDLE) & start & ~abort;
    assign w_abort    = abort & (r_state != IDLE);
    assign w_col_step = w_xfer & ~abort & ~w_last_col;
    assign w_row_step = w_xfer & ~abort & w_last_col & ~w_last_row;

    // Feeds the row counter's count enable, so an aborted beat must not count.
    assign row_advance = w_xfer & w_last_col & ~abort;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state      <= IDLE;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_width      <= '0;
            r_height     <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_width  <= img_width;
                        r_height <= img_height;
                        r_col    <= '0;
                        r_row    <= '0;
                        r_busy   <= 1'b1;
                        if ((img_width == '0) || (img_height == '0)) begin
                            r_state      <= DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= SCAN;
                            r_valid <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_col   <= '0;
                        r_row   <= '0;
                    end else if (w_xfer) begin
                        if (!w_last_col) begin
                            r_col <= r_col + DIM_W'(1);
                        end else if (!w_last_row) begin
                            r_col <= '0;
                            r_row <= r_row + DIM_W'(1);
                        end else begin
                            r_state      <= DONE;
                            r_valid      <= 1'b0;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (abort) begin
                        r_col <= '0;
                        r_row <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    j_scan_addr_unit #(
        .ADDR_W (ADDR_W),
        .BPP    (BPP)
    ) u_addr (
        .clk           (clk),
        .rst           (clear),
        .i_zero        (w_abort),
        .i_load        (w_start_ok),
        .i_base_addr   (base_addr),
        .i_line_stride (line_stride),
        .i_col_step    (w_col_step),
        .i_row_step    (w_row_step),
        .o_pixel_addr  (pixel_addr)
    );

    assign valid      = r_valid;
    assign col        = r_col;
    assign row        = r_row;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_j_pixel_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_j_pixel_scan_ctrl
// Purpose  : Directed self-checking bench for the raster-scan controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_j_pixel_scan_ctrl;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic        abort;
    logic [12:0] img_width;
    logic [12:0] img_height;
    logic [31:0] base_addr;
    logic [31:0] line_stride;
    logic        ready;
    logic        valid;
    logic [31:0] pixel_addr;
    logic [12:0] col;
    logic [12:0] row;
    logic        row_advance;
    logic        frame_done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp6 [6];

    always #5 clk = ~clk;

    j_pixel_scan_ctrl #(
        .DIM_W  (13),
        .ADDR_W (32),
        .BPP    (3)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .abort       (abort),
        .img_width   (img_width),
        .img_height  (img_height),
        .base_addr   (base_addr),
        .line_stride (line_stride),
        .ready       (ready),
        .valid       (valid),
        .pixel_addr  (pixel_addr),
        .col         (col),
        .row         (row),
        .row_advance (row_advance),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Leaves the bench at the first negedge after start was accepted.
    task automatic do_start(input logic [12:0] w, input logic [12:0] h,
                            input logic [31:0] b, input logic [31:0] s);
        @(negedge clk);
        img_width   = w;
        img_height  = h;
        base_addr   = b;
        line_stride = s;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
        img_width = '0; img_height = '0; base_addr = '0; line_stride = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({valid, row_advance, frame_done, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {valid, row_advance, frame_done, busy});
        end
        n_checks++;
        if ({pixel_addr, col, row} !== 58'd0) begin
            n_fail++;
            $display("FAIL reset_indices: addr=%h col=%0d row=%0d expected all 0", pixel_addr, col, row);
        end
        clear = 1'b0;
    endtask

    task automatic test_basic_frame();
        do_start(13'd3, 13'd2, 32'h100, 32'd16);
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++;
            if (valid !== 1'b1 || pixel_addr !== exp6[k] || col !== 13'(k % 3) || row !== 13'(k / 3)) begin
                n_fail++;
                $display("FAIL basic_xfer%0d: valid=%b addr=%h col=%0d row=%0d expected 1 %h %0d %0d",
                         k, valid, pixel_addr, col, row, exp6[k], k % 3, k / 3);
            end
            n_checks++;
            if (row_advance !== ((k % 3) == 2)) begin
                n_fail++;
                $display("FAIL basic_row_adv%0d: got %b expected %b", k, row_advance, (k % 3) == 2);
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if ({frame_done, valid, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL basic_done: {fd,valid,busy}=%b expected 101", {frame_done, valid, busy});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({frame_done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_idle: {fd,busy}=%b expected 00", {frame_done, busy});
        end
    endtask

    task automatic test_ready_toggle();
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        do_start(13'd3, 13'd2, 32'h100, 32'd16);
        while (idx < 6 && cyc < 40) begin
            ready = ((cyc % 3) == 0);
            #1;
            n_checks++;
            if (valid !== 1'b1 || pixel_addr !== exp6[idx] || col !== 13'(idx % 3) || row !== 13'(idx / 3)) begin
                n_fail++;
                $display("FAIL toggle_cyc%0d: valid=%b addr=%h col=%0d row=%0d expected 1 %h %0d %0d",
                         cyc, valid, pixel_addr, col, row, exp6[idx], idx % 3, idx / 3);
            end
            if (ready) idx++;
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (idx != 6) begin
            n_fail++;
            $display("FAIL toggle_timeout: transfers=%0d expected 6", idx);
        end
        #1;
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_done: frame_done=%b expected 1", frame_done);
        end
        ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_dim();
        do_start(13'd0, 13'd5, 32'h300, 32'd8);
        #1;
        n_checks++;
        if ({valid, frame_done, busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL zero_dim_done: {valid,fd,busy}=%b expected 011", {valid, frame_done, busy});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({valid, frame_done, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_dim_idle: {valid,fd,busy}=%b expected 000", {valid, frame_done, busy});
        end
    endtask

    task automatic test_clear_mid();
        do_start(13'd10, 13'd10, 32'h2000, 32'h40);
        ready = 1'b1;
        for (int k = 0; k < 37; k++) begin
            #1;
            if (k == 36) begin
                n_checks++;
                if (pixel_addr !== 32'h20D2 || col !== 13'd6 || row !== 13'd3) begin
                    n_fail++;
                    $display("FAIL clear_pre_xfer37: addr=%h col=%0d row=%0d expected 20d2 6 3", pixel_addr, col, row);
                end
                clear = 1'b1;
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if ({valid, row_advance, frame_done, busy} !== 4'b0000 || {pixel_addr, col, row} !== 58'd0) begin
            n_fail++;
            $display("FAIL clear_mid: flags=%b addr=%h col=%0d row=%0d expected all 0",
                     {valid, row_advance, frame_done, busy}, pixel_addr, col, row);
        end
        clear = 1'b0;
        do_start(13'd4, 13'd2, 32'h5000, 32'h20);
        #1;
        n_checks++;
        if (valid !== 1'b1 || pixel_addr !== 32'h5000 || col !== 13'd0 || row !== 13'd0) begin
            n_fail++;
            $display("FAIL clear_restart: valid=%b addr=%h col=%0d row=%0d expected 1 5000 0 0", valid, pixel_addr, col, row);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int nra;
        int nfd;
        nra = 0;
        nfd = 0;
        do_start(13'd3, 13'd2, 32'h100, 32'd16);
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++;
            if (pixel_addr !== exp6[k]) begin
                n_fail++;
                $display("FAIL ignore_start_addr%0d: got %h expected %h", k, pixel_addr, exp6[k]);
            end
            if (row_advance) nra++;
            start     = (k == 2);
            base_addr = (k == 2) ? 32'h900 : 32'h100;
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            if (frame_done) nfd++;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (nra != 2 || nfd != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_counts: row_adv=%0d fd=%0d busy=%b expected 2 1 0", nra, nfd, busy);
        end
    endtask

    task automatic test_abort();
        do_start(13'd3, 13'd3, 32'h100, 32'd16);
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k == 5) begin
                n_checks++;
                if (col !== 13'd2 || row !== 13'd1 || pixel_addr !== 32'h116) begin
                    n_fail++;
                    $display("FAIL abort_position: col=%0d row=%0d addr=%h expected 2 1 116", col, row, pixel_addr);
                end
                abort = 1'b1;
                #1;
                n_checks++;
                if (row_advance !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_row_adv: got %b expected 0", row_advance);
                end
            end
            @(negedge clk);
        end
        abort = 1'b0;
        #1;
        n_checks++;
        if ({valid, frame_done, busy} !== 3'b000 || {pixel_addr, col, row} !== 58'd0) begin
            n_fail++;
            $display("FAIL abort_idle: {valid,fd,busy}=%b addr=%h col=%0d row=%0d expected all 0",
                     {valid, frame_done, busy}, pixel_addr, col, row);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: frame_done=%b expected 0", frame_done);
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        n_checks++;
        if ({valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_beats_start: {valid,busy}=%b expected 00", {valid, busy});
        end
    endtask

    task automatic test_single_col();
        logic [31:0] exp4 [4];
        int          cnt;
        int          pulses;
        logic        flag;
        exp4   = '{32'h400, 32'h480, 32'h500, 32'h580};
        cnt    = 0;
        pulses = 0;
        flag   = 1'b0;
        do_start(13'd1, 13'd4, 32'h400, 32'h80);
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (pixel_addr !== exp4[k] || row_advance !== 1'b1) begin
                n_fail++;
                $display("FAIL single_col%0d: addr=%h row_adv=%b expected %h 1", k, pixel_addr, row_advance, exp4[k]);
            end
            if (row_advance) begin
                pulses++;
                if (cnt == 3) begin
                    cnt  = 0;
                    flag = 1'b1;
                end else begin
                    cnt++;
                end
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (pulses != 4 || cnt != 0 || flag !== 1'b1) begin
            n_fail++;
            $display("FAIL single_col_rowcnt: pulses=%0d value=%0d rollover=%b expected 4 0 1", pulses, cnt, flag);
        end
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL single_col_done: frame_done=%b expected 1", frame_done);
        end
        @(negedge clk);
    endtask

    initial begin
        exp6 = '{32'h100, 32'h103, 32'h106, 32'h110, 32'h113, 32'h116};
        test_reset();
        test_basic_frame();
        test_ready_toggle();
        test_zero_dim();
        test_clear_mid();
        test_start_ignored();
        test_abort();
        test_single_col();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
